// File: rtl/ibex_bus_arb_pkg.sv
// Shared types for the Ibex instruction/data bus arbiter.
// Defines the owner and arbiter state enums, plus a small helper for owner selection.
package ibex_bus_arb_pkg;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } arb_owner_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Width of the outstanding-response counter (covers depths up to 4).
    localparam int unsigned CountWidth = 3;

    function automatic arb_owner_e other_owner(arb_owner_e o);
        return (o == INSTR) ? DATA : INSTR;
    endfunction

endpackage

// File: rtl/ibex_bus_arb_if.sv
// Bundle of core-side (instruction/data) and host-side bus signals for ibex_bus_arb.
// The slave modport is the arbiter's view: it serves the two core ports and drives the host port.
// The master modport is the surrounding system's view.
interface ibex_bus_arb_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    localparam int unsigned BeWidth = DataWidth / 8;

    // Instruction side
    logic                 instr_req_i;
    logic                 instr_gnt_o;
    logic [AddrWidth-1:0] instr_addr_i;
    logic                 instr_rvalid_o;
    logic [DataWidth-1:0] instr_rdata_o;
    logic                 instr_err_o;

    // Data side
    logic                 data_req_i;
    logic                 data_gnt_o;
    logic                 data_we_i;
    logic [BeWidth-1:0]   data_be_i;
    logic [AddrWidth-1:0] data_addr_i;
    logic [DataWidth-1:0] data_wdata_i;
    logic                 data_rvalid_o;
    logic [DataWidth-1:0] data_rdata_o;
    logic                 data_err_o;

    // Host side (towards the TL-UL host adapter)
    logic                 host_req_o;
    logic                 host_gnt_i;
    logic                 host_we_o;
    logic [BeWidth-1:0]   host_be_o;
    logic [AddrWidth-1:0] host_addr_o;
    logic [DataWidth-1:0] host_wdata_o;
    logic                 host_instr_o;
    logic                 host_rvalid_i;
    logic [DataWidth-1:0] host_rdata_i;
    logic                 host_err_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output host_req_o, host_we_o, host_be_o, host_addr_o, host_wdata_o, host_instr_o,
        input  host_gnt_i, host_rvalid_i, host_rdata_i, host_err_i
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  host_req_o, host_we_o, host_be_o, host_addr_o, host_wdata_o, host_instr_o,
        output host_gnt_i, host_rvalid_i, host_rdata_i, host_err_i
    );

endinterface

// File: rtl/ibex_bus_arb_fifo.sv
// Response-ordering FIFO: remembers which side (1-bit owner ID) each granted
// request belongs to, so in-order host responses can be routed back.
module ibex_bus_arb_fifo
    import ibex_bus_arb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  data_i,
    output logic                  data_o,
    output logic [CountWidth-1:0] count_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrWidth-1:0]   LastPtr    = PtrWidth'(Depth - 1);
    localparam logic [CountWidth-1:0] DepthCount = CountWidth'(Depth);

    logic [Depth-1:0]      mem_q;
    logic [PtrWidth-1:0]   wptr_q, rptr_q;
    logic [CountWidth-1:0] count_q;
    logic                  push_ok, pop_ok;

    // Pointers wrap at the configured depth, which need not be a power of two.
    function automatic logic [PtrWidth-1:0] next_ptr(logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == DepthCount);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

    // Pointer and occupancy bookkeeping; push+pop together keeps the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= next_ptr(wptr_q);
            if (pop_ok)  rptr_q <= next_ptr(rptr_q);
            if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
            else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
        end
    end

    // Owner ID storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/ibex_bus_arb.sv
// Arbiter between the Ibex instruction-fetch and data ports onto one host bus.
// A request shown to the host is held until granted; responses come back in
// order and are routed to the issuing side via a small owner-ID FIFO.
// Build option: define IBEX_BUS_ARB_RR_EN for round-robin arbitration
// (DATA first after reset); otherwise DATA has fixed priority over INSTR.
module ibex_bus_arb
    import ibex_bus_arb_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ibex_bus_arb_if.slave         bus,
    output logic [CountWidth-1:0] outstanding_o,
    output logic                  unexp_rsp_o
);
    localparam int unsigned BeWidth = DataWidth / 8;

    arb_state_e state_q;
    arb_owner_e owner_q;
`ifdef IBEX_BUS_ARB_RR_EN
    arb_owner_e prio_q;
`endif

    arb_owner_e sel_owner, cur_owner, rsp_owner;
    logic       present, push, pop, rsp_instr, rsp_data;
    logic       fifo_head, fifo_full, fifo_empty;

    // Pick a new owner when idle.
    always_comb begin
        sel_owner = bus.data_req_i ? DATA : INSTR;
`ifdef IBEX_BUS_ARB_RR_EN
        if (bus.instr_req_i && bus.data_req_i) sel_owner = prio_q;
`endif
    end

    // A held request keeps its owner; nothing is issued while the FIFO is full or in reset.
    always_comb begin
        cur_owner = (state_q == LOCKED) ? owner_q : sel_owner;
        present   = !rst_i && !fifo_full &&
                    ((state_q == LOCKED) || bus.instr_req_i || bus.data_req_i);
    end

    assign push = present && bus.host_gnt_i;
    assign pop  = !rst_i && bus.host_rvalid_i && !fifo_empty;

    // Drive the host request from the current owner's fields.
    always_comb begin
        bus.host_req_o   = present;
        bus.host_instr_o = 1'b0;
        bus.host_we_o    = 1'b0;
        bus.host_be_o    = {BeWidth{1'b0}};
        bus.host_addr_o  = {AddrWidth{1'b0}};
        bus.host_wdata_o = {DataWidth{1'b0}};
        if (present) begin
            if (cur_owner == DATA) begin
                bus.host_we_o    = bus.data_we_i;
                bus.host_be_o    = bus.data_be_i;
                bus.host_addr_o  = bus.data_addr_i;
                bus.host_wdata_o = bus.data_wdata_i;
            end else begin
                bus.host_instr_o = 1'b1;
                bus.host_be_o    = {BeWidth{1'b1}};
                bus.host_addr_o  = bus.instr_addr_i;
            end
        end
    end

    assign bus.instr_gnt_o = present && (cur_owner == INSTR) && bus.host_gnt_i;
    assign bus.data_gnt_o  = present && (cur_owner == DATA) && bus.host_gnt_i;

    // Route each response to the side at the FIFO head, zeroing idle outputs.
    assign rsp_owner = arb_owner_e'(fifo_head);
    assign rsp_instr = pop && (rsp_owner == INSTR);
    assign rsp_data  = pop && (rsp_owner == DATA);

    always_comb begin
        bus.instr_rvalid_o = rsp_instr;
        bus.instr_rdata_o  = rsp_instr ? bus.host_rdata_i : {DataWidth{1'b0}};
        bus.instr_err_o    = rsp_instr && bus.host_err_i;
        bus.data_rvalid_o  = rsp_data;
        bus.data_rdata_o   = rsp_data ? bus.host_rdata_i : {DataWidth{1'b0}};
        bus.data_err_o     = rsp_data && bus.host_err_i;
    end

    // Arbitration FSM: lock onto an owner while the host stalls the grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= INSTR;
`ifdef IBEX_BUS_ARB_RR_EN
            prio_q  <= DATA;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (present && !bus.host_gnt_i) begin
                        state_q <= LOCKED;
                        owner_q <= sel_owner;
                    end
                end
                LOCKED: begin
                    if (bus.host_gnt_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
`ifdef IBEX_BUS_ARB_RR_EN
            if (push) prio_q <= other_owner(cur_owner);
`endif
        end
    end

    // Sticky flag for responses that arrive with nothing outstanding.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            unexp_rsp_o <= 1'b0;
        end else if (bus.host_rvalid_i && fifo_empty) begin
            unexp_rsp_o <= 1'b1;
        end
    end

    ibex_bus_arb_fifo #(
        .Depth (MaxOutstanding)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (cur_owner == DATA),
        .data_o  (fifo_head),
        .count_o (outstanding_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_ibex_bus_arb.sv
// Self-checking bench for ibex_bus_arb: directed scenarios followed by random
// traffic, all compared against a transaction-level model (pending requests,
// a held-request flag and a queue of outstanding owners).
module tb_ibex_bus_arb;
    localparam int unsigned MAX = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] outstanding;
    logic       unexp_rsp;

    ibex_bus_arb_if #(.AddrWidth(32), .DataWidth(32)) bus ();

    ibex_bus_arb #(
        .MaxOutstanding (MAX),
        .AddrWidth      (32),
        .DataWidth      (32)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bus           (bus),
        .outstanding_o (outstanding),
        .unexp_rsp_o   (unexp_rsp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model state: owner encoding is 1 = data, 0 = instruction.
    bit          pend_i, pend_d;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        d_we;
    logic [3:0]  d_be;
    bit          lock_v, lock_o;
    bit          rr_next = 1'b1;
    bit          unexp_m;
    bit          q[$];

    // One clock cycle: drive at the falling edge, check 1 time unit later,
    // then advance the model to what the next rising edge commits.
    task automatic step(input bit want_i, input bit want_d, input bit gnt, input bit rv,
                        input logic [31:0] rd, input bit er, input bit rst_v);
        bit pres, own, rsp_ok, rsp_own;
        @(negedge clk);
        if (want_i && !pend_i) begin
            pend_i = 1'b1;
            i_addr = $urandom;
        end
        if (want_d && !pend_d) begin
            pend_d  = 1'b1;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_we    = 1'($urandom);
            d_be    = 4'($urandom);
        end
        rst               = rst_v;
        bus.instr_req_i   = pend_i;
        bus.instr_addr_i  = i_addr;
        bus.data_req_i    = pend_d;
        bus.data_addr_i   = d_addr;
        bus.data_wdata_i  = d_wdata;
        bus.data_we_i     = d_we;
        bus.data_be_i     = d_be;
        bus.host_gnt_i    = gnt;
        bus.host_rvalid_i = rv;
        bus.host_rdata_i  = rd;
        bus.host_err_i    = er;
        #1;

        pres = 1'b0;
        own  = 1'b0;
        if (rst_v) begin
            pres = 1'b0;
        end else if (lock_v) begin
            pres = 1'b1;
            own  = lock_o;
        end else if ((pend_i || pend_d) && q.size() < MAX) begin
            pres = 1'b1;
            if (pend_i && pend_d) begin
`ifdef IBEX_BUS_ARB_RR_EN
                own = rr_next;
`else
                own = 1'b1;
`endif
            end else begin
                own = pend_d;
            end
        end

        check_eq("host_req", bus.host_req_o, pres);
        check_eq("instr_gnt", bus.instr_gnt_o, pres && !own && gnt);
        check_eq("data_gnt", bus.data_gnt_o, pres && own && gnt);
        if (pres) begin
            check_eq("host_instr", bus.host_instr_o, !own);
            check_eq("host_addr", bus.host_addr_o, own ? d_addr : i_addr);
            check_eq("host_we", bus.host_we_o, own ? d_we : 1'b0);
            check_eq("host_be", bus.host_be_o, own ? d_be : 4'hF);
            check_eq("host_wdata", bus.host_wdata_o, own ? d_wdata : 32'h0);
        end

        rsp_ok  = !rst_v && rv && (q.size() > 0);
        rsp_own = (q.size() > 0) ? q[0] : 1'b0;
        check_eq("instr_rvalid", bus.instr_rvalid_o, rsp_ok && !rsp_own);
        check_eq("instr_rdata", bus.instr_rdata_o, (rsp_ok && !rsp_own) ? rd : 32'h0);
        check_eq("instr_err", bus.instr_err_o, rsp_ok && !rsp_own && er);
        check_eq("data_rvalid", bus.data_rvalid_o, rsp_ok && rsp_own);
        check_eq("data_rdata", bus.data_rdata_o, (rsp_ok && rsp_own) ? rd : 32'h0);
        check_eq("data_err", bus.data_err_o, rsp_ok && rsp_own && er);
        if (!rst_v) begin
            check_eq("outstanding", outstanding, q.size());
            check_eq("unexp_rsp", unexp_rsp, unexp_m);
        end

        if (rst_v) begin
            q.delete();
            lock_v  = 1'b0;
            rr_next = 1'b1;
            unexp_m = 1'b0;
        end else begin
            if (rv) begin
                if (q.size() > 0) void'(q.pop_front());
                else unexp_m = 1'b1;
            end
            if (pres && gnt) begin
                q.push_back(own);
                if (own) pend_d = 1'b0;
                else pend_i = 1'b0;
                lock_v  = 1'b0;
                rr_next = !own;
            end else if (pres) begin
                lock_v = 1'b1;
                lock_o = own;
            end
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.instr_req_i   = 1'b0;
        bus.instr_addr_i  = '0;
        bus.data_req_i    = 1'b0;
        bus.data_we_i     = 1'b0;
        bus.data_be_i     = '0;
        bus.data_addr_i   = '0;
        bus.data_wdata_i  = '0;
        bus.host_gnt_i    = 1'b0;
        bus.host_rvalid_i = 1'b0;
        bus.host_rdata_i  = '0;
        bus.host_err_i    = 1'b0;

        // Reset with requests and a response present: all outputs quiet.
        step(1, 1, 1, 1, 32'h1111_1111, 1, 1);
        pend_i = 1'b0;
        pend_d = 1'b0;
        step(0, 0, 0, 0, 0, 0, 1);

        // Simultaneous requests, grant always high; in-order responses.
        step(1, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hA5A5_A5A5, 0, 0);
        step(0, 0, 0, 1, 32'h1234_5678, 1, 0);

        // Data request stalled three cycles while instruction request rises.
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hCAFE_0001, 0, 0);
        step(0, 0, 0, 1, 32'hCAFE_0002, 0, 0);

        // FIFO full: no request even when a response pops in the same cycle.
        step(0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 32'hBEEF_0001, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hBEEF_0002, 0, 0);
        step(0, 0, 0, 1, 32'hBEEF_0003, 0, 0);

        // Response with nothing outstanding: dropped, sticky flag.
        step(0, 0, 0, 1, 32'hDEAD_BEEF, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        // Both sides requesting continuously with grant high.
        step(1, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(1, 1, 1, 1, $urandom, 0, 0);
        pend_i = 1'b0;
        pend_d = 1'b0;
        step(0, 0, 0, 0, 0, 0, 1);

        // Reset with one outstanding and one held request.
        step(0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        pend_i = 1'b0;
        pend_d = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0BAD_0BAD, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h600D_600D, 0, 0);

        // Random traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            bit r, g, v;
            r = ($urandom_range(0, 99) == 0);
            g = ($urandom_range(0, 3) != 0);
            v = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            step(1'($urandom), 1'($urandom), g, v, $urandom, 1'($urandom), r);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ibex_bus_arb.md
IBEX_BUS_ARB -- requirements
Module: ibex_bus_arb

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2: depth of the response-ordering FIFO (1..4).
REQ-002 SHALL have parameter AddrWidth, default 32: address width.
REQ-003 SHALL have parameter DataWidth, default 32: data width; byte-enable width is DataWidth/8.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have these ports: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have these instruction-side ports: instr_req_i in 1; instr_gnt_o out 1; instr_addr_i in AddrWidth; instr_rvalid_o out 1; instr_rdata_o out DataWidth; instr_err_o out 1.
REQ-007 SHALL have these data-side ports: data_req_i in 1; data_gnt_o out 1; data_we_i in 1; data_be_i in DataWidth/8; data_addr_i in AddrWidth; data_wdata_i in DataWidth; data_rvalid_o out 1; data_rdata_o out DataWidth; data_err_o out 1.
REQ-008 SHALL have these host-side ports (to the TL-UL host adapter): host_req_o out 1; host_gnt_i in 1; host_we_o out 1; host_be_o out DataWidth/8; host_addr_o out AddrWidth; host_wdata_o out DataWidth; host_instr_o out 1 (1 = fetch); host_rvalid_i in 1; host_rdata_i in DataWidth; host_err_i in 1.
REQ-009 SHALL have these status ports: outstanding_o out 3 (current FIFO count); unexp_rsp_o out 1 (sticky).

Function
REQ-010 SHALL arbitrate in two states: IDLE and LOCKED(owner in {INSTR, DATA}).
REQ-011 In IDLE, with any req asserted and FIFO not full, SHALL select an owner, drive host_req_o=1 with that owner's fields in the same cycle, and go to LOCKED if host_gnt_i=0.
REQ-012 In LOCKED, SHALL keep presenting the owner's request unchanged until host_gnt_i=1, then return to IDLE; requests from the other side are ignored meanwhile.
REQ-013 SHALL assert the owner's gnt_o combinationally equal to host_gnt_i while presenting; the non-owner gnt_o SHALL be 0.
REQ-014 SHALL drive host_req_o=0 when FIFO count equals MaxOutstanding, even if a pop occurs in the same cycle.
REQ-015 For an instruction request, SHALL drive host_we_o=0, host_be_o all ones, host_wdata_o=0, host_instr_o=1.
REQ-016 On each host_req_o&&host_gnt_i, SHALL push the owner ID into the ordering FIFO.
REQ-017 On each host_rvalid_i, SHALL pop the FIFO head and route rdata/err to that side's rvalid/rdata/err in the same cycle (zero latency); the other side's rvalid SHALL be 0.
REQ-018 Simultaneous push and pop SHALL leave the count unchanged; FIFO pointers SHALL wrap modulo MaxOutstanding.
REQ-019 A host_rvalid_i with an empty FIFO SHALL be dropped (no rvalid on either side) and SHALL set unexp_rsp_o until reset.
REQ-020 Routed rdata_o SHALL be driven 0 whenever that side's rvalid_o=0.

Reset
REQ-021 While rst_i=1 (sampled on clk_i), SHALL go to IDLE and clear the FIFO pointers, count and unexp_rsp_o; all gnt/rvalid/host_req outputs SHALL be 0 during reset.
REQ-022 Reset mid-transaction SHALL abandon a held request and all pending responses; responses arriving afterwards fall under REQ-019.

Configuration
REQ-023 SHALL support the macro IBEX_BUS_ARB_RR_EN: when defined, arbitration in IDLE SHALL be round-robin, with priority going to the side not granted last (DATA first after reset).
REQ-024 When IBEX_BUS_ARB_RR_EN is undefined, arbitration in IDLE SHALL be fixed priority, with DATA over INSTR.

Structure
REQ-025 The arb_owner_e enum (INSTR=0, DATA=1) and the arb_state_e enum SHALL live in the shared package ibex_bus_arb_pkg.
REQ-026 The ordering FIFO SHALL be a sub-module, ibex_bus_arb_fifo (1-bit entries, depth MaxOutstanding, push/pop/count/full/empty).

Verification
REQ-027 Both reqs at once, host_gnt_i=1, fixed-priority build: data granted cycle 0, instr cycle 1; rvalids return rdata 0xA5A5A5A5 to data, then 0x12345678 to instr, in order.
REQ-028 Data req with host_gnt_i held 0 for 3 cycles while instr_req_i rises: the host fields stay equal to the data request on all 4 cycles, and instr_gnt_o=0 throughout.
REQ-029 MaxOutstanding=2 with two grants and no responses: host_req_o=0 and outstanding_o=2; after one host_rvalid_i, the next request is granted.
REQ-030 host_rvalid_i=1 with an empty FIFO: no rvalid on either side, and unexp_rsp_o=1 until rst_i.
REQ-031 RR build with both sides requesting continuously and host_gnt_i=1: grants alternate D,I,D,I; host_instr_o toggles each cycle.
REQ-032 rst_i asserted with 1 outstanding and one request held: the next cycle has outstanding_o=0 and state IDLE, and a later host_rvalid_i sets unexp_rsp_o.
